// File: rtl/uart_tx_stream_if.sv
// Write-side handshake between a producer and the UART transmit FIFO.
interface uart_tx_stream_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_stream.sv
// UART transmitter with a write FIFO, configurable framing and a frame-boundary enable.
// A word is popped only at frame launch; back-to-back frames leave no idle gap.
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enb,
  uart_tx_stream_if.slave             wr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        tx_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Odd mode inverts the plain XOR of the payload.
  function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
    parity_f = (PARITY_MODE == 1) ? ~(^d) : (^d);
  endfunction

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  state_t               state_q;
  logic [BW-1:0]        baud_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q, tx_q, busy_q;
  logic                 wr_ready_s, do_wr_s, do_pop_s, baud_end_s, stop_end_s;
  logic [DATA_BITS-1:0] head_s;

  // Handshake, launch decision and occupancy update.
  always_comb begin
    wr_ready_s = (count_q < CW'(FIFO_DEPTH));
    do_wr_s    = wr.wr_valid && wr_ready_s;
    baud_end_s = (baud_q == BW'(CLKS_PER_BIT - 1));
    stop_end_s = (state_q == ST_STOP) && baud_end_s && (bit_q == 4'(STOP_BITS - 1));
    do_pop_s   = enb && (count_q != {CW{1'b0}}) && ((state_q == ST_IDLE) || stop_end_s);
    head_s     = mem_q[rd_ptr_q];
    if (do_wr_s && !do_pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!do_wr_s && do_pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  assign wr.wr_ready = wr_ready_s;
  assign fifo_count  = count_q;
  assign busy        = busy_q;
  assign tx_data     = tx_q;

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr.wr_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= {BW{1'b0}};
      bit_q   <= 4'd0;
      shift_q <= {DATA_BITS{1'b0}};
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baud_q <= {BW{1'b0}};
          bit_q  <= 4'd0;
          if (do_pop_s) begin
            shift_q <= head_s;
            par_q   <= parity_f(head_s);
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end_s) begin
            baud_q  <= {BW{1'b0}};
            bit_q   <= 4'd0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_end_s) begin
            baud_q <= {BW{1'b0}};
            if (bit_q == 4'(DATA_BITS - 1)) begin
              bit_q <= 4'd0;
              if (PARITY_MODE != 0) begin
                tx_q    <= par_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              bit_q   <= bit_q + 4'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        ST_PARITY: begin
          if (baud_end_s) begin
            baud_q  <= {BW{1'b0}};
            bit_q   <= 4'd0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        ST_STOP: begin
          if (baud_end_s) begin
            baud_q <= {BW{1'b0}};
            if (bit_q == 4'(STOP_BITS - 1)) begin
              bit_q <= 4'd0;
              // Chain straight into the next start bit when more data is waiting.
              if (do_pop_s) begin
                shift_q <= head_s;
                par_q   <= parity_f(head_s);
                tx_q    <= 1'b0;
                state_q <= ST_START;
              end else begin
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench: 8N1 instance plus even- and odd-parity instances, CLKS_PER_BIT = 4.
module tb_uart_tx_stream;
  logic       clk, rst, enb;
  logic       tx, busy, tx_e, busy_e, tx_o, busy_o;
  logic [4:0] cnt, cnt_e, cnt_o;
  int         checks = 0;
  int         failures = 0;

  uart_tx_stream_if #(.DATA_BITS(8)) w_if ();
  uart_tx_stream_if #(.DATA_BITS(8)) we_if ();
  uart_tx_stream_if #(.DATA_BITS(8)) wo_if ();

  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut (.clk(clk), .rst(rst), .enb(enb), .wr(w_if.slave), .fifo_count(cnt), .busy(busy), .tx_data(tx));
  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut_e (.clk(clk), .rst(rst), .enb(enb), .wr(we_if.slave), .fifo_count(cnt_e), .busy(busy_e), .tx_data(tx_e));
  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut_o (.clk(clk), .rst(rst), .enb(enb), .wr(wo_if.slave), .fifo_count(cnt_o), .busy(busy_o), .tx_data(tx_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level k cycles into an 8N1 frame (start, LSB-first data, stop).
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k < 4) return 1'b0;
    else if (k < 36) return d[(k - 4) / 4];
    else return 1'b1;
  endfunction

  task automatic wr_word(input logic [7:0] d);
    @(negedge clk);
    w_if.wr_valid = 1'b1;
    w_if.wr_data  = d;
    @(posedge clk);
    #1;
    w_if.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    #2;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || cnt !== 5'd0 || w_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset tx=%b busy=%b cnt=%0d rdy=%b exp 1 0 0 1", tx, busy, cnt, w_if.wr_ready);
    end
    checks++;
    if (tx_e !== 1'b1 || tx_o !== 1'b1 || cnt_e !== 5'd0 || cnt_o !== 5'd0) begin
      failures++;
      $display("FAIL reset_par tx_e=%b tx_o=%b cnt_e=%0d cnt_o=%0d exp 1 1 0 0", tx_e, tx_o, cnt_e, cnt_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    enb = 1'b1;
    wr_word(8'hA5);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt !== 5'd1) begin
      failures++;
      $display("FAIL basic_pre busy=%b cnt=%0d exp 0 1", busy, cnt);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== frame_bit(8'hA5, k) || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_frame k=%0d tx=%b busy=%b exp tx=%b busy=1", k, tx, busy, frame_bit(8'hA5, k));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || cnt !== 5'd0) begin
      failures++;
      $display("FAIL basic_post busy=%b tx=%b cnt=%0d exp 0 1 0", busy, tx, cnt);
    end
  endtask

  task automatic test_parity();
    logic exp_e, exp_o;
    enb = 1'b1;
    @(negedge clk);
    we_if.wr_valid = 1'b1; we_if.wr_data = 8'h07;
    wo_if.wr_valid = 1'b1; wo_if.wr_data = 8'h07;
    @(posedge clk);
    #1;
    we_if.wr_valid = 1'b0;
    wo_if.wr_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k < 36) begin
        exp_e = frame_bit(8'h07, k); exp_o = exp_e;
      end else if (k < 40) begin
        exp_e = 1'b1; exp_o = 1'b0;
      end else begin
        exp_e = 1'b1; exp_o = 1'b1;
      end
      checks++;
      if (tx_e !== exp_e || tx_o !== exp_o || busy_e !== 1'b1 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL parity_frame k=%0d tx_e=%b tx_o=%b busy_e=%b busy_o=%b exp %b %b 1 1",
                 k, tx_e, tx_o, busy_e, busy_o, exp_e, exp_o);
      end
    end
    @(negedge clk);
    checks++;
    if (busy_e !== 1'b0 || busy_o !== 1'b0 || tx_e !== 1'b1 || tx_o !== 1'b1) begin
      failures++;
      $display("FAIL parity_post busy_e=%b busy_o=%b tx_e=%b tx_o=%b exp 0 0 1 1", busy_e, busy_o, tx_e, tx_o);
    end
  endtask

  task automatic test_fill();
    logic [7:0] d;
    enb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (w_if.wr_ready !== (i < 16)) begin
        failures++;
        $display("FAIL fill_ready i=%0d rdy=%b exp %b", i, w_if.wr_ready, (i < 16));
      end
      w_if.wr_valid = 1'b1;
      w_if.wr_data  = 8'(8'h10 + i);
    end
    @(negedge clk);
    w_if.wr_valid = 1'b0;
    checks++;
    if (cnt !== 5'd16 || w_if.wr_ready !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fill_full cnt=%0d rdy=%b tx=%b busy=%b exp 16 0 1 0", cnt, w_if.wr_ready, tx, busy);
    end
    enb = 1'b1;
    for (int w = 0; w < 16; w++) begin
      d = 8'(8'h10 + w);
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        checks++;
        if (tx !== frame_bit(d, k) || busy !== 1'b1) begin
          failures++;
          $display("FAIL drain_frame w=%0d k=%0d tx=%b busy=%b exp tx=%b busy=1", w, k, tx, busy, frame_bit(d, k));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt !== 5'd0 || w_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_post busy=%b cnt=%0d rdy=%b exp 0 0 1", busy, cnt, w_if.wr_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    enb = 1'b0;
    wr_word(8'h01);
    wr_word(8'h02);
    wr_word(8'h03);
    @(negedge clk);
    checks++;
    if (cnt !== 5'd3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pre cnt=%0d busy=%b exp 3 0", cnt, busy);
    end
    enb = 1'b1;
    for (int w = 0; w < 3; w++) begin
      d = 8'(w + 1);
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        checks++;
        if (tx !== frame_bit(d, k) || busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_frame w=%0d k=%0d tx=%b busy=%b exp tx=%b busy=1", w, k, tx, busy, frame_bit(d, k));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || cnt !== 5'd0) begin
      failures++;
      $display("FAIL b2b_post busy=%b tx=%b cnt=%0d exp 0 1 0", busy, tx, cnt);
    end
  endtask

  task automatic test_enb_drop();
    enb = 1'b0;
    wr_word(8'h3C);
    wr_word(8'hC3);
    @(negedge clk);
    enb = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== frame_bit(8'h3C, k) || busy !== 1'b1) begin
        failures++;
        $display("FAIL drop_frame1 k=%0d tx=%b busy=%b exp tx=%b busy=1", k, tx, busy, frame_bit(8'h3C, k));
      end
      if (k == 10) enb = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || cnt !== 5'd1) begin
      failures++;
      $display("FAIL drop_idle busy=%b tx=%b cnt=%0d exp 0 1 1", busy, tx, cnt);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || cnt !== 5'd1) begin
      failures++;
      $display("FAIL drop_hold busy=%b tx=%b cnt=%0d exp 0 1 1", busy, tx, cnt);
    end
    enb = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== frame_bit(8'hC3, k) || busy !== 1'b1) begin
        failures++;
        $display("FAIL drop_frame2 k=%0d tx=%b busy=%b exp tx=%b busy=1", k, tx, busy, frame_bit(8'hC3, k));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt !== 5'd0) begin
      failures++;
      $display("FAIL drop_post busy=%b cnt=%0d exp 0 0", busy, cnt);
    end
  endtask

  task automatic test_reset_mid();
    enb = 1'b0;
    wr_word(8'h5A);
    wr_word(8'h66);
    @(negedge clk);
    enb = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1 || cnt !== 5'd1) begin
      failures++;
      $display("FAIL rstmid_pre tx=%b busy=%b cnt=%0d exp 0 1 1", tx, busy, cnt);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || cnt !== 5'd0 || w_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async tx=%b busy=%b cnt=%0d rdy=%b exp 1 0 0 1", tx, busy, cnt, w_if.wr_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    wr_word(8'h81);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt !== 5'd1) begin
      failures++;
      $display("FAIL rstmid_wr busy=%b cnt=%0d exp 0 1", busy, cnt);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== frame_bit(8'h81, k) || busy !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_frame k=%0d tx=%b busy=%b exp tx=%b busy=1", k, tx, busy, frame_bit(8'h81, k));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || cnt !== 5'd0) begin
      failures++;
      $display("FAIL rstmid_post busy=%b tx=%b cnt=%0d exp 0 1 0", busy, tx, cnt);
    end
  endtask

  initial begin
    enb = 1'b0;
    w_if.wr_valid  = 1'b0; w_if.wr_data  = 8'h00;
    we_if.wr_valid = 1'b0; we_if.wr_data = 8'h00;
    wo_if.wr_valid = 1'b0; wo_if.wr_data = 8'h00;
    test_reset();
    test_basic();
    test_parity();
    test_fill();
    test_back_to_back();
    test_enb_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Parametrised UART transmitter with an integrated write FIFO; drives the board-level `tx_data` serial line from FPGA_top.
- Streams inference results and status bytes to the host.
- Successor to the fixed 8N1 transmitter: configurable data width, parity, stop bits, baud divisor and buffer depth.
- Adds a global enable (`enb`) with graceful frame completion.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be ≥ 2
- DATA_BITS, 8, payload bits per frame; 5..9
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame; 1 or 2
- FIFO_DEPTH, 16, entries in the write FIFO; power of 2, ≥ 2

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- enb  input  1  transmit enable; gates the start of new frames only
- wr_valid  input  1  write request
- wr_data  input  DATA_BITS  payload byte/word
- wr_ready  output  1  FIFO can accept a write
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- busy  output  1  frame in progress (state != IDLE)
- tx_data  output  1  serial line, idle high

Behaviour:
- Reset (rst = 0, asynchronous) forces:
  - tx_data = 1, busy = 0, fifo_count = 0, wr_ready = 1
  - FSM = IDLE; baud counter, bit counter and FIFO pointers = 0
  - Reset mid-frame aborts the frame immediately; FIFO contents are discarded.
- FIFO:
  - Write occurs when wr_valid && wr_ready.
  - wr_ready = (fifo_count < FIFO_DEPTH), computed combinationally from the registered count.
  - When full, wr_ready = 0; writes are ignored and no data is lost or overwritten.
  - Pop occurs only when the FSM launches a frame.
  - Simultaneous write and pop: count unchanged; both operations take effect.
  - No same-cycle pass-through: a word written into an empty FIFO is poppable the next cycle at the earliest.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Launch condition:
  - In IDLE, if enb = 1 and fifo_count > 0: pop the head word into the shift register, go to START.
  - tx_data = 0 from the next cycle.
- Bit timing:
  - Every serial bit holds tx_data for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and advances the state/bit on the terminal count.
- START: drive 0; then go to DATA.
- DATA:
  - Drive LSB first; shift right once per bit.
  - The bit counter runs 0..DATA_BITS-1.
  - Then go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - Drive the XOR of all payload bits (even mode), or its inverse (odd mode).
  - Parity is computed from the popped word, not from the shifting register.
- STOP: drive 1 for STOP_BITS × CLKS_PER_BIT cycles.
- End of the last stop bit:
  - If enb = 1 and fifo_count > 0, pop and go directly to START with no idle gap.
  - Otherwise go to IDLE.
- Frame length: exactly (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- enb:
  - Deasserting enb mid-frame does not truncate the frame; it completes, then the FSM idles.
  - FIFO writes are accepted regardless of enb.
- busy: 1 from the cycle after the pop through the final stop-bit cycle; 0 in IDLE.
- All outputs except wr_ready are registered; tx_data has no combinational path from any input.

Test Plan:
- CLKS_PER_BIT = 4, 8N1; write 0xA5 with enb = 1 -> tx_data low for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles; busy high for exactly 40 cycles; fifo_count back to 0.
- PARITY_MODE = 2, write 0x07 -> parity bit 1; PARITY_MODE = 1, write 0x07 -> parity bit 0; frame length 44 cycles.
- enb = 0, attempt 20 writes -> first 16 accepted, wr_ready = 0 after the 16th, fifo_count = 16, tx_data stays 1; then raise enb -> 16 frames sent in FIFO order, fifo_count ends at 0.
- Three back-to-back writes 0x01, 0x02, 0x03, 8N1, CLKS_PER_BIT = 4 -> busy continuously high for 120 cycles; each start bit immediately follows the previous stop bit.
- Two words queued; drop enb during frame 1's data bits -> frame 1 completes intact, FSM idles, fifo_count = 1; re-raise enb -> frame 2 sent.
- Assert rst = 0 mid data bit -> tx_data = 1, busy = 0, fifo_count = 0 in the same cycle (asynchronous); after release, a new write transmits correctly.
